// File: rtl/instr_issue_unit.sv
// Instruction fetch/issue front end: PC, single-outstanding imem fetch, decode handshake, local JUMP.
// Optional macro HALT_ON_ILLEGAL_EN: illegal opcodes halt the unit instead of being skipped.
module instr_issue_unit #(
    parameter int INSTR_W  = 16,
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic               ins_valid,
    input  logic               ins_ready,
    output logic [2:0]         control_opcode,
    output logic [INSTR_W-4:0] ins_operands,
    output logic [PC_W-1:0]    ins_pc,
    output logic [15:0]        issue_count,
    output logic               illegal
);

    localparam logic [2:0] OP_JUMP = 3'b011;

    typedef enum logic [1:0] {
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_e;

    state_e               state_q;
    logic [PC_W-1:0]      pc_q;
    logic [PC_W-1:0]      pc_d;
    logic [PC_W-1:0]      pc_inc;
    logic                 req_q;
    logic                 valid_q;
    logic [INSTR_W-1:0]   instr_q;
    logic [PC_W-1:0]      ins_pc_q;
    logic [15:0]          count_q;
    logic [15:0]          count_d;
    logic [2:0]           fetch_opc;
    logic                 fetch_illegal;
`ifdef HALT_ON_ILLEGAL_EN
    logic                 illegal_q;
`endif

    always_comb begin
        fetch_opc     = imem_rdata[INSTR_W-1 -: 3];
        fetch_illegal = (fetch_opc == 3'b000) || (fetch_opc == 3'b111);
        pc_inc        = pc_q + PC_W'(1);
        // Jump target is the low PC_W bits of the operand field.
        if (instr_q[INSTR_W-1 -: 3] == OP_JUMP) begin
            pc_d = instr_q[PC_W-1:0];
        end else begin
            pc_d = pc_inc;
        end
        count_d = (count_q == '1) ? count_q : count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= PC_W'(RESET_PC);
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            ins_pc_q <= '0;
            count_q  <= '0;
`ifdef HALT_ON_ILLEGAL_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem_valid) begin
                        req_q <= 1'b0;
                        if (fetch_illegal) begin
`ifdef HALT_ON_ILLEGAL_EN
                            instr_q   <= imem_rdata;
                            ins_pc_q  <= pc_q;
                            illegal_q <= 1'b1;
                            state_q   <= S_HALT;
`else
                            // Skipped word leaves the last issued instruction on the outputs.
                            pc_q <= pc_inc;
`endif
                        end else begin
                            instr_q  <= imem_rdata;
                            ins_pc_q <= pc_q;
                            valid_q  <= 1'b1;
                            state_q  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (ins_ready) begin
                        valid_q <= 1'b0;
                        pc_q    <= pc_d;
                        count_q <= count_d;
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: begin
                    // Left only through rst.
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = pc_q;
    assign ins_valid      = valid_q;
    assign control_opcode = instr_q[INSTR_W-1 -: 3];
    assign ins_operands   = instr_q[INSTR_W-4:0];
    assign ins_pc         = ins_pc_q;
    assign issue_count    = count_q;
`ifdef HALT_ON_ILLEGAL_EN
    assign illegal        = illegal_q;
`else
    assign illegal        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed self-checking bench for instr_issue_unit with a 1-cycle-latency instruction memory model.
module tb_instr_issue_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        ins_valid;
    logic        ins_ready;
    logic [2:0]  control_opcode;
    logic [12:0] ins_operands;
    logic [7:0]  ins_pc;
    logic [15:0] issue_count;
    logic        illegal;

    logic [15:0] mem [256];
    logic        mem_auto;
    int          checks;
    int          failures;
    int          exp_count;

    instr_issue_unit #(
        .INSTR_W (16),
        .PC_W    (8),
        .RESET_PC(0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .ins_valid     (ins_valid),
        .ins_ready     (ins_ready),
        .control_opcode(control_opcode),
        .ins_operands  (ins_operands),
        .ins_pc        (ins_pc),
        .issue_count   (issue_count),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers a request seen at the falling edge, so data is sampled on the next rising edge.
    always @(negedge clk) begin
        if (mem_auto) begin
            imem_valid = imem_req;
            imem_rdata = mem[imem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_req", imem_req, 0);
        check("rst_valid", ins_valid, 0);
        check("rst_opcode", control_opcode, 0);
        check("rst_operands", ins_operands, 0);
        check("rst_pc", ins_pc, 0);
        check("rst_count", issue_count, 0);
        check("rst_illegal", illegal, 0);
    endtask

    task automatic wait_req(input logic [7:0] exp_addr);
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = imem_req;
        end
        check("req_seen", seen, 1);
        check("req_addr", imem_addr, exp_addr);
    endtask

    task automatic issue_one(input logic [15:0] word, input logic [7:0] pc, input bit early);
        bit seen = 0;
        ins_ready = early;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = ins_valid;
        end
        check("issue_seen", seen, 1);
        check("issue_opcode", control_opcode, word[15:13]);
        check("issue_operands", ins_operands, word & 16'h1FFF);
        check("issue_pc", ins_pc, pc);
        ins_ready = 1'b1;
        @(negedge clk);
        ins_ready = 1'b0;
        if (exp_count < 16'hFFFF) exp_count++;
        check("issue_drop", ins_valid, 0);
        check("issue_count", issue_count, exp_count);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        exp_count  = 0;
        mem_auto   = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = '0;
        ins_ready  = 1'b0;
        rst        = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = 16'h2000;
        mem[0]    = 16'h8000;
        mem[1]    = 16'h2000;
        mem[2]    = 16'h4000;
        mem[3]    = 16'h6042;
        mem[8'h42] = 16'hA005;
        mem[8'h43] = 16'h60FF;
        mem[8'hFF] = 16'h8000;

        @(negedge clk);
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        @(negedge clk);
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 0);
        issue_one(16'h8000, 8'h00, 1'b0);
        wait_req(8'h01);

        issue_one(16'h2000, 8'h01, 1'b0);
        issue_one(16'h4000, 8'h02, 1'b0);
        issue_one(16'h6042, 8'h03, 1'b0);
        wait_req(8'h42);

        // Stall the decode side on ADDI for 10 cycles.
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = ins_valid;
            end
            check("stall_seen", seen, 1);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("stall_valid", ins_valid, 1);
                check("stall_opcode", control_opcode, 3'b101);
                check("stall_req", imem_req, 0);
                check("stall_count", issue_count, exp_count);
            end
        end
        issue_one(16'hA005, 8'h42, 1'b0);

        issue_one(16'h60FF, 8'h43, 1'b0);
        issue_one(16'h8000, 8'hFF, 1'b0);
        mem_auto   = 1'b0;
        imem_valid = 1'b0;
        wait_req(8'h00);

        // Reset while a fetch is outstanding; a late response must be ignored.
        rst = 1'b1;
        exp_count = 0;
        @(negedge clk);
        check_reset_values();
        rst        = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 16'hA0FF;
        @(negedge clk);
        imem_valid = 1'b0;
        check("rr_req", imem_req, 1);
        check("rr_addr", imem_addr, 0);
        check("rr_valid", ins_valid, 0);
        @(negedge clk);
        check("rr_valid2", ins_valid, 0);
        check("rr_req2", imem_req, 1);

        mem[3] = 16'h2000;
        mem[4] = 16'h2000;
        mem[5] = 16'hE000;
        mem[6] = 16'h4000;
        mem_auto = 1'b1;
        issue_one(16'h8000, 8'h00, 1'b1);
        for (int a = 1; a < 5; a++) issue_one(mem[a], 8'(a), 1'b0);

        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                seen = imem_req && (imem_addr == 8'h05);
            end
            check("ill_fetch_seen", seen, 1);
        end
        @(negedge clk);
        check("ill_valid", ins_valid, 0);
        check("ill_req", imem_req, 0);
`ifdef HALT_ON_ILLEGAL_EN
        check("halt_flag", illegal, 1);
        check("halt_pc", ins_pc, 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("halt_req", imem_req, 0);
            check("halt_valid", ins_valid, 0);
            check("halt_flag_hold", illegal, 1);
            check("halt_addr", imem_addr, 5);
        end
        rst = 1'b1;
        exp_count = 0;
        @(negedge clk);
        rst = 1'b0;
        check("halt_rst_flag", illegal, 0);
        issue_one(16'h8000, 8'h00, 1'b0);
`else
        @(negedge clk);
        check("skip_req", imem_req, 1);
        check("skip_addr", imem_addr, 6);
        check("skip_count", issue_count, 5);
        check("skip_flag", illegal, 0);
        check("skip_valid", ins_valid, 0);
        issue_one(16'h4000, 8'h06, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
